// File: rtl/axil_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// axil_cmd_seq_if
//   Bundles every non-clock signal of axil_cmd_seq: the user command and
//   response streams, the command FIFO occupancy, and the user-side
//   interface of the downstream AXI4-Lite master.
//
//   modport slave  : the sequencer's view (axil_cmd_seq uses this)
//   modport master : the view of whatever drives commands and models the
//                    AXI4-Lite master (the environment around the sequencer)
//
//   Parameters DEPTH / ADDR_W / DATA_W must match those of axil_cmd_seq.
// ---------------------------------------------------------------------------
interface axil_cmd_seq_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // user command stream
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [CNT_W-1:0]  cmd_count;

    // user response stream
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // AXI4-Lite master user side
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] user_waddr;
    logic [ADDR_W-1:0] user_raddr;
    logic [DATA_W-1:0] user_wdata;
    logic [DATA_W-1:0] user_rdata;
    logic              wr_ready;
    logic              rd_ready;
    logic              wr_error;
    logic              rd_error;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  user_rdata, wr_ready, rd_ready, wr_error, rd_error,
        output cmd_ready, cmd_count,
        output rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_err,
        output write, read, user_waddr, user_raddr, user_wdata
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output user_rdata, wr_ready, rd_ready, wr_error, rd_error,
        input  cmd_ready, cmd_count,
        input  rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_err,
        input  write, read, user_waddr, user_raddr, user_wdata
    );
endinterface

// File: rtl/axil_cmd_seq.sv
// ---------------------------------------------------------------------------
// axil_cmd_seq
//   Command sequencer in front of an AXI4-Lite master's user-side interface.
//   User commands are queued in a DEPTH-entry command FIFO and issued one at
//   a time as single-cycle write/read pulses. After the matching completion
//   pulse the result (type, address, read data, error) is queued in a
//   DEPTH-entry response FIFO. Exactly one transaction is outstanding on the
//   master at any time, and a command is only issued when a response slot
//   is free, so completions are never dropped.
//
// Ports
//   aclk    : clock
//   areset  : synchronous, active-high reset
//   bus     : axil_cmd_seq_if.slave -- command stream (cmd_*), response
//             stream (rsp_*), cmd_count, and the master user side
//             (write/read, user_waddr/user_raddr/user_wdata, user_rdata,
//             wr_ready/rd_ready, wr_error/rd_error)
//   stat_wr_cnt / stat_rd_cnt / stat_err_cnt (16-bit, saturating):
//             completion statistics, present only when the macro
//             AXIL_CMD_SEQ_STATS_EN is defined.
// ---------------------------------------------------------------------------
module axil_cmd_seq #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          aclk,
    input  logic          areset,
    axil_cmd_seq_if.slave bus
`ifdef AXIL_CMD_SEQ_STATS_EN
    ,
    output logic [15:0]   stat_wr_cnt,
    output logic [15:0]   stat_rd_cnt,
    output logic [15:0]   stat_err_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic              cmd_w_mem [DEPTH];
    logic [ADDR_W-1:0] cmd_a_mem [DEPTH];
    logic [DATA_W-1:0] cmd_d_mem [DEPTH];
    logic [PTR_W-1:0]  cmd_wp, cmd_rp;
    logic [CNT_W-1:0]  cmd_cnt;
    logic              cmd_full, cmd_empty, cmd_push, cmd_pop;

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic              rsp_w_mem [DEPTH];
    logic [ADDR_W-1:0] rsp_a_mem [DEPTH];
    logic [DATA_W-1:0] rsp_d_mem [DEPTH];
    logic              rsp_e_mem [DEPTH];
    logic [PTR_W-1:0]  rsp_wp, rsp_rp;
    logic [CNT_W-1:0]  rsp_cnt;
    logic              rsp_full, rsp_empty, rsp_push, rsp_pop;

    // ------------------------------------------------------------------
    // Issue FSM and held transaction
    // ------------------------------------------------------------------
    logic [1:0]        state;
    logic              cur_write;
    logic              write_q, read_q;
    logic [ADDR_W-1:0] waddr_q, raddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              done;

    logic              new_w;
    logic [ADDR_W-1:0] new_a;
    logic [DATA_W-1:0] new_d;
    logic              new_e;

    assign cmd_full  = (cmd_cnt == FULL_CNT);
    assign cmd_empty = (cmd_cnt == '0);
    assign rsp_full  = (rsp_cnt == FULL_CNT);
    assign rsp_empty = (rsp_cnt == '0);

    // A full FIFO never accepts, even if the FSM pops in the same cycle.
    assign cmd_push = bus.cmd_valid && !cmd_full;
    // Issuing only with a free response slot means the completion can
    // always be pushed without backpressure on the master.
    assign cmd_pop  = (state == S_IDLE) && !cmd_empty && !rsp_full;

    // Only the ready pulse matching the outstanding type completes it.
    assign done     = (state == S_WAIT) && (cur_write ? bus.wr_ready : bus.rd_ready);
    assign rsp_push = done;
    assign rsp_pop  = !rsp_empty && bus.rsp_ready;

    assign new_w = cur_write;
    assign new_a = cur_write ? waddr_q : raddr_q;
    assign new_d = cur_write ? '0 : bus.user_rdata;
    assign new_e = cur_write ? bus.wr_error : bus.rd_error;

    // Storage arrays carry no reset; occupancy counters gate visibility.
    always_ff @(posedge aclk) begin
        if (cmd_push) begin
            cmd_w_mem[cmd_wp] <= bus.cmd_write;
            cmd_a_mem[cmd_wp] <= bus.cmd_addr;
            cmd_d_mem[cmd_wp] <= bus.cmd_wdata;
        end
        if (rsp_push) begin
            rsp_w_mem[rsp_wp] <= new_w;
            rsp_a_mem[rsp_wp] <= new_a;
            rsp_d_mem[rsp_wp] <= new_d;
            rsp_e_mem[rsp_wp] <= new_e;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
            rsp_wp  <= '0;
            rsp_rp  <= '0;
            rsp_cnt <= '0;
        end else begin
            if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
            if (cmd_pop)  cmd_rp <= cmd_rp + 1'b1;
            if (cmd_push && !cmd_pop)      cmd_cnt <= cmd_cnt + 1'b1;
            else if (cmd_pop && !cmd_push) cmd_cnt <= cmd_cnt - 1'b1;

            if (rsp_push) rsp_wp <= rsp_wp + 1'b1;
            if (rsp_pop)  rsp_rp <= rsp_rp + 1'b1;
            if (rsp_push && !rsp_pop)      rsp_cnt <= rsp_cnt + 1'b1;
            else if (rsp_pop && !rsp_push) rsp_cnt <= rsp_cnt - 1'b1;
        end
    end

    // IDLE -> ISSUE -> WAIT -> IDLE; the pulse register is set on entry
    // to ISSUE so write/read are high for exactly the ISSUE cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= S_IDLE;
            cur_write <= 1'b0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            waddr_q   <= '0;
            raddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_pop) begin
                        cur_write <= cmd_w_mem[cmd_rp];
                        if (cmd_w_mem[cmd_rp]) begin
                            waddr_q <= cmd_a_mem[cmd_rp];
                            wdata_q <= cmd_d_mem[cmd_rp];
                            write_q <= 1'b1;
                        end else begin
                            raddr_q <= cmd_a_mem[cmd_rp];
                            read_q  <= 1'b1;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    write_q <= 1'b0;
                    read_q  <= 1'b0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) state <= S_IDLE;
                end
                default: begin
                    write_q <= 1'b0;
                    read_q  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AXIL_CMD_SEQ_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge aclk) begin
        if (areset) begin
            stat_wr_cnt  <= '0;
            stat_rd_cnt  <= '0;
            stat_err_cnt <= '0;
        end else if (done) begin
            if (cur_write) stat_wr_cnt <= sat_inc(stat_wr_cnt);
            else           stat_rd_cnt <= sat_inc(stat_rd_cnt);
            if (new_e)     stat_err_cnt <= sat_inc(stat_err_cnt);
        end
    end
`endif

    assign bus.cmd_ready  = !cmd_full;
    assign bus.cmd_count  = cmd_cnt;
    assign bus.write      = write_q;
    assign bus.read       = read_q;
    assign bus.user_waddr = waddr_q;
    assign bus.user_raddr = raddr_q;
    assign bus.user_wdata = wdata_q;

    // Response fields read as zero while the FIFO is empty so stale
    // storage never leaks out after reset.
    assign bus.rsp_valid  = !rsp_empty;
    assign bus.rsp_write  = !rsp_empty && rsp_w_mem[rsp_rp];
    assign bus.rsp_addr   = rsp_empty ? '0 : rsp_a_mem[rsp_rp];
    assign bus.rsp_rdata  = rsp_empty ? '0 : rsp_d_mem[rsp_rp];
    assign bus.rsp_err    = !rsp_empty && rsp_e_mem[rsp_rp];
endmodule

// File: tb/tb_axil_cmd_seq.sv
module tb_axil_cmd_seq;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          e;
    } rsp_t;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } iss_t;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    axil_cmd_seq_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef AXIL_CMD_SEQ_STATS_EN
    logic [15:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

    axil_cmd_seq #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
`ifdef AXIL_CMD_SEQ_STATS_EN
        ,
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_rd_cnt  (stat_rd_cnt),
        .stat_err_cnt (stat_err_cnt)
`endif
    );

    // master model drives and spurious-pulse injectors
    logic          m_wr_ready = 1'b0, m_rd_ready = 1'b0;
    logic          m_wr_error = 1'b0, m_rd_error = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          sp_wr_ready = 1'b0, sp_rd_ready = 1'b0;
    int            m_delay = 2;
    logic          m_hold = 1'b0;

    assign bus.wr_ready   = m_wr_ready | sp_wr_ready;
    assign bus.rd_ready   = m_rd_ready | sp_rd_ready;
    assign bus.wr_error   = m_wr_error;
    assign bus.rd_error   = m_rd_error;
    assign bus.user_rdata = m_rdata;

    int n_vec  = 0;
    int n_fail = 0;
    int tb_wr_n = 0, tb_rd_n = 0, tb_err_n = 0;

    rsp_t exp_rsp [$];
    iss_t exp_iss [$];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // ---------------- response monitor / scoreboard ----------------
    rsp_t mon_got, mon_exp;
    initial begin
        forever begin
            @(negedge aclk);
            if (!areset && bus.rsp_valid && bus.rsp_ready) begin
                mon_got = {bus.rsp_write, bus.rsp_addr, bus.rsp_rdata, bus.rsp_err};
                if (exp_rsp.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got %0h required none", mon_got);
                end else begin
                    mon_exp = exp_rsp.pop_front();
                    check("rsp", mon_got, mon_exp);
                    if (mon_exp.w) tb_wr_n++; else tb_rd_n++;
                    if (mon_exp.e) tb_err_n++;
                end
            end
        end
    end

    // ---------------- behavioural AXI4-Lite master ----------------
    logic [DW-1:0] mem [logic [AW-1:0]];
    iss_t          m_iss;
    logic          m_abort, m_err;
    initial begin
        forever begin
            @(negedge aclk);
            if (!areset && (bus.write || bus.read)) begin
                m_iss = {bus.write, bus.write ? bus.user_waddr : bus.user_raddr,
                         bus.write ? bus.user_wdata : 32'h0};
                if (exp_iss.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL issue_unexpected: got %0h required none", m_iss);
                end else begin
                    check("issue", m_iss, exp_iss.pop_front());
                end
                m_abort = 1'b0;
                @(negedge aclk);
                if (areset) m_abort = 1'b1;
                check("pulse_width", {bus.write, bus.read}, 2'b00);
                for (int k = 1; k < m_delay; k++) begin
                    @(negedge aclk);
                    if (areset) m_abort = 1'b1;
                end
                while (m_hold && !m_abort) begin
                    @(negedge aclk);
                    if (areset) m_abort = 1'b1;
                end
                if (!m_abort) begin
                    m_err = (m_iss.a == 32'h200);
                    if (m_iss.w) begin
                        if (!m_err) mem[m_iss.a] = m_iss.d;
                        m_wr_error = m_err;
                        m_wr_ready = 1'b1;
                    end else begin
                        m_rdata    = (!m_err && mem.exists(m_iss.a)) ? mem[m_iss.a] : 32'h0;
                        m_rd_error = m_err;
                        m_rd_ready = 1'b1;
                    end
                    @(negedge aclk);
                    m_wr_ready = 1'b0;
                    m_rd_ready = 1'b0;
                    m_wr_error = 1'b0;
                    m_rd_error = 1'b0;
                    m_rdata    = '0;
                    if (!areset) check("rsp_valid_latency", bus.rsp_valid, 1'b1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] er, input logic ee);
        logic acc;
        exp_iss.push_back({w, a, w ? d : 32'h0});
        exp_rsp.push_back({w, a, er, ee});
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge aclk);
            acc = bus.cmd_ready;
            @(posedge aclk);
            #1;
        end
        if (!acc) begin
            n_vec++;
            n_fail++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 required 1");
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (exp_rsp.size() == 0 && exp_iss.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge aclk);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d responses pending required 0", exp_rsp.size());
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        areset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        cycles(3);
        areset = 1'b0;
        @(negedge aclk);
        // reset state
        check("rst_cmd_count", bus.cmd_count, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_fields", {bus.rsp_write, bus.rsp_addr, bus.rsp_rdata, bus.rsp_err}, 0);
        check("rst_wr_rd", {bus.write, bus.read}, 0);
        check("rst_user_regs", {bus.user_waddr, bus.user_raddr, bus.user_wdata}, 0);
        @(posedge aclk);
        #1;

        // single write with issue latency
        send(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        @(negedge aclk);
        check("lat_count_after_push", bus.cmd_count, 1);
        check("lat_no_pulse_yet", bus.write, 0);
        @(negedge aclk);
        check("lat_write_pulse", bus.write, 1);
        check("lat_waddr_wdata", {bus.user_waddr, bus.user_wdata}, {32'h10, 32'hDEADBEEF});
        check("lat_count_after_pop", bus.cmd_count, 0);
        @(posedge aclk);
        #1;
        wait_drain(100);

        // write then read back
        send(1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0);
        send(1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);
        wait_drain(100);

        // error path
        send(1'b0, 32'h200, 32'h0, 32'h0, 1'b1);
        send(1'b1, 32'h200, 32'h55AA55AA, 32'h0, 1'b1);
        wait_drain(100);

        // backpressure: 5 commands, no response pops
        bus.rsp_ready = 1'b0;
        send(1'b1, 32'h40, 32'h11111111, 32'h0, 1'b0);
        send(1'b1, 32'h44, 32'h22222222, 32'h0, 1'b0);
        send(1'b0, 32'h40, 32'h0, 32'h11111111, 1'b0);
        send(1'b0, 32'h44, 32'h0, 32'h22222222, 1'b0);
        send(1'b1, 32'h48, 32'h33333333, 32'h0, 1'b0);
        @(negedge aclk);
        check("bp_cmd_count_full", bus.cmd_count, 4);
        check("bp_cmd_ready_low", bus.cmd_ready, 0);
        cycles(80);
        @(negedge aclk);
        check("bp_one_left_queued", bus.cmd_count, 1);
        check("bp_rsp_held", bus.rsp_valid, 1);
        check("bp_head_is_first", {bus.rsp_write, bus.rsp_addr, bus.rsp_rdata, bus.rsp_err},
              {1'b1, 32'h40, 32'h0, 1'b0});
        @(posedge aclk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_drain(200);
        check("bp_drained_count", bus.cmd_count, 0);

        // spurious pulses
        m_hold = 1'b1;
        send(1'b1, 32'h60, 32'hCAFEF00D, 32'h0, 1'b0);
        cycles(5);
        sp_rd_ready = 1'b1;
        cycles(1);
        sp_rd_ready = 1'b0;
        cycles(2);
        @(negedge aclk);
        check("spur_rd_in_wait_rsp", bus.rsp_valid, 0);
        check("spur_rd_in_wait_pulses", {bus.write, bus.read}, 0);
        @(posedge aclk);
        #1;
        m_hold = 1'b0;
        wait_drain(100);
        sp_wr_ready = 1'b1;
        cycles(1);
        sp_wr_ready = 1'b0;
        cycles(2);
        @(negedge aclk);
        check("spur_wr_in_idle_rsp", bus.rsp_valid, 0);
        check("spur_wr_in_idle_state", {bus.cmd_count, bus.write, bus.read}, 0);
        @(posedge aclk);
        #1;
        send(1'b0, 32'h60, 32'h0, 32'hCAFEF00D, 1'b0);
        wait_drain(100);

`ifdef AXIL_CMD_SEQ_STATS_EN
        @(negedge aclk);
        check("stat_wr", stat_wr_cnt, 16'(tb_wr_n));
        check("stat_rd", stat_rd_cnt, 16'(tb_rd_n));
        check("stat_err", stat_err_cnt, 16'(tb_err_n));
        @(posedge aclk);
        #1;
`endif

        // reset during WAIT with two queued commands
        m_hold = 1'b1;
        send(1'b1, 32'h80, 32'hA5A5A5A5, 32'h0, 1'b0);
        send(1'b0, 32'h84, 32'h0, 32'h0, 1'b0);
        send(1'b1, 32'h88, 32'h5A5A5A5A, 32'h0, 1'b0);
        cycles(3);
        @(negedge aclk);
        check("rstw_queued", bus.cmd_count, 2);
        @(posedge aclk);
        #1;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_iss.delete();
        exp_rsp.delete();
        @(negedge aclk);
        check("rstw_cmd_count", bus.cmd_count, 0);
        check("rstw_rsp_valid", bus.rsp_valid, 0);
        check("rstw_pulses", {bus.write, bus.read}, 0);
        check("rstw_cmd_ready", bus.cmd_ready, 1);
        @(posedge aclk);
        #1;
        m_hold = 1'b0;
        sp_wr_ready = 1'b1;
        cycles(1);
        sp_wr_ready = 1'b0;
        cycles(3);
        @(negedge aclk);
        check("stale_ready_rsp", bus.rsp_valid, 0);
        check("stale_ready_state", {bus.cmd_count, bus.write, bus.read}, 0);
`ifdef AXIL_CMD_SEQ_STATS_EN
        check("rstw_stats_zero", {stat_wr_cnt, stat_rd_cnt, stat_err_cnt}, 0);
`endif
        @(posedge aclk);
        #1;

        // sequencer still works after reset
        send(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        wait_drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
